// File: rtl/seg7_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan : time-multiplexed N-digit seven-segment driver with dead-time, |
// | per-frame input snapshot and optional leading-zero blanking. Rev 1.0      |
// +--------------------------------------------------------------------------+
module seg7_scan #(
   parameter int NUM_DIGITS    = 8,
   parameter int CLK_DIV       = 100000,
   parameter int GAP_CYCLES    = 16,
   parameter int LZ_SUPPRESS   = 0,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [4*NUM_DIGITS-1:0]       val,
   input  logic [NUM_DIGITS-1:0]         dp,
   input  logic [NUM_DIGITS-1:0]         blank,
   output logic [7:0]                    seg,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_start
);

   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX);
   localparam logic [NUM_DIGITS-1:0] AN_OFF =
      (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_GAP   = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] val_s_q, val_s_d;
   logic [NUM_DIGITS-1:0]   dp_s_q, dp_s_d;
   logic [NUM_DIGITS-1:0]   blank_s_q, blank_s_d;
   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    fs_q, fs_d;

   logic [4*NUM_DIGITS-1:0] src_val;
   logic [NUM_DIGITS-1:0]   src_dp, src_blank, lead;
   logic                    all_zero;
   logic [3:0]              nib;
   logic                    dp_bit, blank_bit, lead_bit;
   logic [7:0]              dec, drv_seg;
   logic [NUM_DIGITS-1:0]   drv_an;

   function automatic logic [7:0] hex7(input logic [3:0] n);
      logic [7:0] s;
      s = 8'hFF;
      case (n)
         4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
         4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
         4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
         4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  4'hF: s = 8'h8E;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Digit 0 is latched on the same edge it is first shown, so it must read the live inputs.
   always_comb begin
      src_val   = (idx_q == '0) ? val   : val_s_q;
      src_dp    = (idx_q == '0) ? dp    : dp_s_q;
      src_blank = (idx_q == '0) ? blank : blank_s_q;
      all_zero  = 1'b1;
      lead      = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero & (src_val[4*i +: 4] == 4'h0);
         lead[i]  = all_zero && (i != 0) && (LZ_SUPPRESS != 0);
      end
      nib       = src_val[{idx_q, 2'b00} +: 4];
      dp_bit    = src_dp[idx_q];
      blank_bit = src_blank[idx_q];
      lead_bit  = lead[idx_q];
      dec       = hex7(nib);
      drv_seg   = 8'hFF;
      drv_an    = AN_OFF;
      if (!(blank_bit || (lead_bit && !dp_bit))) begin
         drv_an  = (AN_ACTIVE_LOW != 0) ? ~(ONE_HOT0 << idx_q) : (ONE_HOT0 << idx_q);
         drv_seg = lead_bit ? 8'h7F : {dec[7] & ~dp_bit, dec[6:0]};
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      val_s_d   = val_s_q;
      dp_s_d    = dp_s_q;
      blank_s_d = blank_s_q;
      seg_d     = seg_q;
      an_d      = an_q;
      fs_d      = 1'b0;
      if (!en) begin
         state_d = ST_GAP;
         cnt_d   = '0;
         idx_d   = '0;
         seg_d   = 8'hFF;
         an_d    = AN_OFF;
      end else begin
         case (state_q)
            ST_GAP: begin
               if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                  state_d = ST_DRIVE;
                  cnt_d   = '0;
                  seg_d   = drv_seg;
                  an_d    = drv_an;
                  fs_d    = (idx_q == '0);
                  if (idx_q == '0) begin
                     val_s_d   = val;
                     dp_s_d    = dp;
                     blank_s_d = blank;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_DRIVE: begin
               if (cnt_q == CW'(CLK_DIV - 1)) begin
                  state_d = ST_GAP;
                  cnt_d   = '0;
                  seg_d   = 8'hFF;
                  an_d    = AN_OFF;
                  idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = ST_GAP;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_GAP;
         cnt_q     <= '0;
         idx_q     <= '0;
         val_s_q   <= '0;
         dp_s_q    <= '0;
         blank_s_q <= '0;
         seg_q     <= 8'hFF;
         an_q      <= AN_OFF;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         val_s_q   <= val_s_d;
         dp_s_q    <= dp_s_d;
         blank_s_q <= blank_s_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
         fs_q      <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign digit_idx   = idx_q;
   assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg7_scan : checks two seg7_scan instances (LZ off / LZ on) against a  |
// | frame-position reference model. Rev 1.0                                   |
// +--------------------------------------------------------------------------+
module tb_seg7_scan;

   localparam int N = 4;
   localparam int C = 4;
   localparam int G = 2;
   localparam int P = G + C;
   localparam int F = N * P;
   localparam logic [7:0] SEG_TAB [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b1;
   logic [15:0] val = 16'h0000;
   logic [3:0]  dp = 4'h0;
   logic [3:0]  blank = 4'h0;
   logic [7:0]  seg_a, seg_b;
   logic [3:0]  an_a, an_b;
   logic [1:0]  idx_a, idx_b;
   logic        fs_a, fs_b;

   int checks = 0;
   int errors = 0;
   int k = 0;
   logic [15:0] s_val = 16'h0000;
   logic [3:0]  s_dp = 4'h0;
   logic [3:0]  s_blank = 4'h0;

   always #5 clk = ~clk;

   seg7_scan #(.NUM_DIGITS(N), .CLK_DIV(C), .GAP_CYCLES(G), .LZ_SUPPRESS(0), .AN_ACTIVE_LOW(1)) dut_a (
      .clk(clk), .rst(rst), .en(en), .val(val), .dp(dp), .blank(blank),
      .seg(seg_a), .an(an_a), .digit_idx(idx_a), .frame_start(fs_a));

   seg7_scan #(.NUM_DIGITS(N), .CLK_DIV(C), .GAP_CYCLES(G), .LZ_SUPPRESS(1), .AN_ACTIVE_LOW(1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .val(val), .dp(dp), .blank(blank),
      .seg(seg_b), .an(an_b), .digit_idx(idx_b), .frame_start(fs_b));

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h (k=%0d t=%0t)", tag, got, exp, k, $time);
      end
   endtask

   // Expected display for one instance, derived from frame position and the captured inputs.
   task automatic model(input bit lz, input int slot, input bit drv,
                        output logic [7:0] es, output logic [3:0] ea);
      logic [15:0] upper;
      bit          lead, d;
      es = 8'hFF;
      ea = 4'hF;
      if (drv) begin
         upper = s_val >> (4 * slot);
         d     = s_dp[slot];
         lead  = lz && (slot != 0) && (upper == 16'h0);
         if (!(s_blank[slot] || (lead && !d))) begin
            ea = ~(4'b0001 << slot);
            if (lead)   es = 8'h7F;
            else if (d) es = SEG_TAB[upper[3:0]] & 8'h7F;
            else        es = SEG_TAB[upper[3:0]];
         end
      end
   endtask

   task automatic check_all();
      int         slot;
      bit         drv, efs;
      logic [7:0] es;
      logic [3:0] ea;
      slot = (k / P) % N;
      drv  = (k % P) >= G;
      efs  = (k % F) == G;
      model(1'b0, slot, drv, es, ea);
      chk("seg_a", seg_a, es);
      chk("an_a", {4'h0, an_a}, {4'h0, ea});
      chk("idx_a", {6'h0, idx_a}, 8'(slot));
      chk("fs_a", {7'h0, fs_a}, {7'h0, efs});
      chk("onehot_a", {7'h0, ($countones(~an_a) <= 1)}, 8'h01);
      model(1'b1, slot, drv, es, ea);
      chk("seg_b", seg_b, es);
      chk("an_b", {4'h0, an_b}, {4'h0, ea});
      chk("idx_b", {6'h0, idx_b}, 8'(slot));
      chk("fs_b", {7'h0, fs_b}, {7'h0, efs});
   endtask

   task automatic check_dark(input string tag);
      chk({tag, "_seg_a"}, seg_a, 8'hFF);
      chk({tag, "_an_a"}, {4'h0, an_a}, 8'h0F);
      chk({tag, "_idx_a"}, {6'h0, idx_a}, 8'h00);
      chk({tag, "_fs_a"}, {7'h0, fs_a}, 8'h00);
      chk({tag, "_seg_b"}, seg_b, 8'hFF);
      chk({tag, "_an_b"}, {4'h0, an_b}, 8'h0F);
   endtask

   task automatic step();
      @(posedge clk);
      if (!en) k = 0;
      else     k++;
      if ((k % F) == G) begin
         s_val   = val;
         s_dp    = dp;
         s_blank = blank;
      end
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic sync_frame();
      int guard = 0;
      while ((k % F) != 0 && guard < 100) begin
         step();
         guard++;
      end
      chk("sync_frame_timeout", {7'h0, guard < 100}, 8'h01);
   endtask

   task automatic sync_drive(input int slot);
      int guard = 0;
      while (!(((k / P) % N) == slot && (k % P) == G + 1) && guard < 200) begin
         step();
         guard++;
      end
      chk("sync_drive_timeout", {7'h0, guard < 200}, 8'h01);
   endtask

   task automatic frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      sync_frame();
      val = v; dp = d; blank = b;
      run(F);
   endtask

   initial begin
      // Asynchronous reset, checked before any clock edge.
      #1 rst = 1'b1;
      #1 check_dark("rst_async");
      @(posedge clk);
      #1 check_dark("rst_held");
      #2 rst = 1'b0;
      k = 0; s_val = '0; s_dp = '0; s_blank = '0;
      run(F);

      // Scan order and snapshot across a mid-frame input change.
      frame(16'h1234, 4'h0, 4'h0);
      frame(16'h1234, 4'h0, 4'h0);
      sync_drive(1);
      val = 16'h5678;
      run(F + P);

      // Decode sweep on digit 0, including DP with an 8.
      for (int n = 0; n < 16; n++)
         frame({$urandom_range(65535)} & 16'hFFF0 | 16'(n), 4'h0, 4'h0);
      frame(16'h0008, 4'h1, 4'h0);

      // Leading zeros, blanking and DP on a suppressed digit.
      frame(16'h0040, 4'h0, 4'h0);
      frame(16'h0000, 4'h0, 4'h0);
      frame(16'h0000, 4'h0, 4'h1);
      frame(16'h0000, 4'h4, 4'h0);
      frame(16'h0005, 4'h6, 4'h0);

      // Randomised inputs changing at arbitrary points, with occasional enable drops.
      for (int c = 0; c < 20 * F; c++) begin
         if ($urandom_range(7) == 0) begin
            val   = 16'($urandom);
            if ($urandom_range(1) == 0) val = val & 16'h00FF;
            dp    = 4'($urandom);
            blank = 4'($urandom_range(3) == 0 ? $urandom : 0);
         end
         en = ($urandom_range(39) != 0);
         step();
      end
      en = 1'b1;

      // Enable dropped during digit 2 drive, then restored.
      val = 16'h1234; dp = 4'h0; blank = 4'h0;
      run(F);
      sync_drive(2);
      en = 1'b0;
      step();
      check_dark("en_low");
      step();
      en = 1'b1;
      run(F);

      // Reset asserted mid-drive takes effect without a clock edge.
      sync_drive(1);
      #2 rst = 1'b1;
      #1 check_dark("rst_mid");
      #1 rst = 1'b0;
      k = 0; s_val = '0; s_dp = '0; s_blank = '0;
      run(F + P);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Parametrised multi-digit, time-multiplexed seven-segment display driver.
- Takes NUM_DIGITS packed hex nibbles plus per-digit decimal-point and blank controls, and scans one digit at a time onto a shared segment bus and per-digit anode lines.
- Inserts a dead-time gap between digits to prevent ghosting, snapshots inputs once per frame to prevent tearing, and optionally suppresses leading zeros.
- Sits between the datapath/status logic and the board display pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; must be >= 2.
- CLK_DIV, 100000: clk cycles each digit is driven; must be >= 2.
- GAP_CYCLES, 16: clk cycles of all-off dead time before each digit; must be >= 1.
- LZ_SUPPRESS, 0: 1 = blank leading zero digits.
- AN_ACTIVE_LOW, 1: 1 = anode asserted as 0; 0 = anode asserted as 1.

Ports:
- clk, input, 1: system clock; all state on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: scan enable; 0 blanks the display and restarts the frame.
- val, input, 4*NUM_DIGITS: hex nibbles; digit i = val[4i+3:4i]; digit 0 is rightmost/least significant.
- dp, input, NUM_DIGITS: decimal point request per digit.
- blank, input, NUM_DIGITS: force digit i dark.
- seg, output, 8: registered, active-low segments; bit7 = DP, bits6..0 = g,f,e,d,c,b,a.
- an, output, NUM_DIGITS: registered anode enables, polarity per AN_ACTIVE_LOW.
- digit_idx, output, clog2(NUM_DIGITS): index of the digit currently or next driven.
- frame_start, output, 1: one-cycle pulse in the first DRIVE cycle of digit 0.

Behaviour:
- Reset (asynchronous, immediate):
  - seg = 8'hFF; an = all de-asserted; digit_idx = 0; frame_start = 0.
  - State = GAP; cycle counter = 0; snapshot registers = 0.
- States:
  - GAP: seg = 8'hFF, an all off; lasts GAP_CYCLES cycles, then goes to DRIVE.
  - DRIVE: lasts CLK_DIV cycles, then goes to GAP with digit_idx incremented. Wrap: NUM_DIGITS-1 goes to 0.
- Outputs are registered and loaded on the same edge as the state transition, so seg/an are valid in the first cycle of each state.
- Snapshot:
  - On the GAP->DRIVE edge with digit_idx = 0, val/dp/blank are captured. The digit 0 output uses the values sampled on that edge.
  - All digits in a frame display snapshot values. Input changes mid-frame take effect only at the next frame.
- frame_start is high for exactly the first DRIVE cycle of digit 0.
- Frame length = NUM_DIGITS*(GAP_CYCLES+CLK_DIV) cycles.
- Decode (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - DP: if dp[i] is set, bit7 is cleared.
- Dark digit, in DRIVE: an stays off and seg = 8'hFF for the full slot; timing is unchanged. A digit is dark if either:
  - blank[i] = 1; or
  - LZ_SUPPRESS = 1 and digits NUM_DIGITS-1..i are all zero and i != 0. Digit 0 is never suppressed.
  - A suppressed digit with dp[i] = 1 is NOT dark. It drives seg = 8'h7F (DP only).
- en = 0, sampled on any edge:
  - Next edge: seg = FF, an off, state = GAP, counter = 0, digit_idx = 0, frame_start = 0.
  - Held there while en = 0.
  - When en returns to 1, the normal GAP then digit 0 sequence resumes, with a new snapshot and frame_start.
- Reset mid-DRIVE: outputs go dark asynchronously; the sequence restarts as after power-up.
- Only one anode may ever be asserted in any cycle.
- Each DRIVE slot must be preceded by at least GAP_CYCLES all-off cycles.

Test Plan:
Settings: NUM_DIGITS=4, CLK_DIV=4, GAP_CYCLES=2, AN_ACTIVE_LOW=1 unless noted.
- Reset and first digit: assert rst with val=16'h0000, en=1 → seg=FF and an=1111 immediately. After release: 2 cycles of 1111, then an=1110, seg=C0, frame_start=1 for 1 cycle.
- Scan order and timing: val=16'h1234 → an cycles 1110/1101/1011/0111 for 4 cycles each, separated by 2-cycle 1111 gaps, with seg 99/B0/A4/F9. frame_start period = 24 cycles. Never more than one 0 in an.
- Decode sweep: drive each nibble 0..F on digit 0 across 16 frames → seg matches the decode table exactly. dp[0]=1 with value 8 → seg=00.
- Snapshot: val=16'h1234; switch to 16'h5678 during digit 1 DRIVE → digits 2 and 3 still show A4 and F9. The next frame shows 80/F8/82/92.
- Blank and leading-zero: LZ_SUPPRESS=1, val=16'h0040 → digits 3 and 2 dark (an off, seg FF), digit 1 = 99, digit 0 = C0. With val=0, only digit 0 lit (C0). Add blank[0]=1 → digit 0 dark. With dp[2]=1 → digit 2 drives 7F.
- en / reset mid-operation: drop en during digit 2 DRIVE → next edge an=1111, seg=FF, digit_idx=0. Raise en → 2 gap cycles, then digit 0 with frame_start. Assert rst mid-DRIVE → an=1111 and seg=FF without waiting for a clock edge.
